// File: rtl/calc_key_if.sv
// Keypad-to-calculator bundle: key stream in, operand triple and display out.
// The slave side is the key-entry block; the master side is whoever feeds keys and consumes results.
interface calc_key_if #(
  parameter int NB = 48
) ();
  logic                 key_valid;
  logic [4:0]           key_code;
  logic                 key_ready;
  logic signed [NB-1:0] a;
  logic signed [NB-1:0] b;
  logic [2:0]           operand;
  logic                 out_valid;
  logic                 out_ready;
  logic signed [NB-1:0] disp;
  logic                 digit_ovf;

  modport slave (
    input  key_valid, key_code, out_ready,
    output key_ready, a, b, operand, out_valid, disp, digit_ovf
  );

  modport master (
    output key_valid, key_code, out_ready,
    input  key_ready, a, b, operand, out_valid, disp, digit_ovf
  );
endinterface

// File: rtl/calc_key_entry.sv
// Keypad front end: assembles signed a, operator and signed b from a key stream
// and hands them to the combinational calculator over a valid/ready handshake.
module calc_key_entry #(
  parameter int NB         = 48,
  parameter int MAX_DIGITS = 14
) (
  input logic       clk,
  input logic       rst,
  calc_key_if.slave kif
);

  localparam int             DCW  = $clog2(MAX_DIGITS + 1);
  localparam logic [DCW-1:0] DMAX = DCW'(MAX_DIGITS);

  typedef enum logic [1:0] {ENTER_A, ENTER_B, ISSUE} state_t;

  state_t               state;
  logic [NB-1:0]        acc, acc_nxt;
  logic                 sign, sign_nxt;
  logic [DCW-1:0]       dcnt, dcnt_nxt;
  logic                 ovf, ovf_nxt;
  logic                 key_ready;
  logic                 out_valid;
  logic signed [NB-1:0] a, b, disp;
  logic [2:0]           operand;

  logic                 accept, issue_done;
  logic                 is_digit, is_op, is_eq, is_clr, is_neg;
  logic                 entry_empty;
  logic [NB-1:0]        digit;

  function automatic logic signed [NB-1:0] apply_sign(input logic [NB-1:0] mag,
                                                       input logic neg);
    logic signed [NB-1:0] s;
    s = $signed(mag);
    return neg ? -s : s;
  endfunction

  assign accept      = kif.key_valid && key_ready;
  assign issue_done  = out_valid && kif.out_ready;
  assign is_digit    = kif.key_code <= 5'd9;
  assign is_op       = (kif.key_code >= 5'd10) && (kif.key_code <= 5'd13);
  assign is_eq       = kif.key_code == 5'd14;
  assign is_clr      = kif.key_code == 5'd15;
  assign is_neg      = kif.key_code == 5'd16;
  assign digit       = NB'(kif.key_code[3:0]);
  assign entry_empty = (dcnt == '0) && (acc == '0) && !sign;

  // Entry datapath; leading zeros do not consume a digit slot.
  always_comb begin
    acc_nxt  = acc;
    sign_nxt = sign;
    dcnt_nxt = dcnt;
    ovf_nxt  = ovf;
    if (accept) begin
      if (is_digit) begin
        if (dcnt < DMAX) begin
          acc_nxt = acc * NB'(10) + digit;
          if (!((acc == '0) && (digit == '0))) dcnt_nxt = dcnt + 1'b1;
        end else begin
          ovf_nxt = 1'b1;
        end
      end else if (is_neg) begin
        sign_nxt = !sign;
      end else if (is_op && (state == ENTER_A)) begin
        acc_nxt  = '0;
        sign_nxt = 1'b0;
        dcnt_nxt = '0;
      end else if (is_clr) begin
        acc_nxt  = '0;
        sign_nxt = 1'b0;
        dcnt_nxt = '0;
        ovf_nxt  = 1'b0;
      end
    end else if (issue_done) begin
      acc_nxt  = '0;
      sign_nxt = 1'b0;
      dcnt_nxt = '0;
      ovf_nxt  = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= ENTER_A;
      acc       <= '0;
      sign      <= 1'b0;
      dcnt      <= '0;
      ovf       <= 1'b0;
      disp      <= '0;
      a         <= '0;
      b         <= '0;
      operand   <= '0;
      out_valid <= 1'b0;
      key_ready <= 1'b1;
    end else begin
      acc  <= acc_nxt;
      sign <= sign_nxt;
      dcnt <= dcnt_nxt;
      ovf  <= ovf_nxt;
      disp <= apply_sign(acc_nxt, sign_nxt);
      case (state)
        ENTER_A: begin
          if (accept && is_op) begin
            a       <= apply_sign(acc, sign);
            operand <= 3'(kif.key_code - 5'd10);
            state   <= ENTER_B;
          end
        end
        ENTER_B: begin
          if (accept) begin
            if (is_op && entry_empty) begin
              operand <= 3'(kif.key_code - 5'd10);
            end else if (is_eq) begin
              b         <= apply_sign(acc, sign);
              out_valid <= 1'b1;
              key_ready <= 1'b0;
              state     <= ISSUE;
            end else if (is_clr) begin
              state <= ENTER_A;
            end
          end
        end
        ISSUE: begin
          if (issue_done) begin
            out_valid <= 1'b0;
            key_ready <= 1'b1;
            state     <= ENTER_A;
          end
        end
        default: state <= ENTER_A;
      endcase
    end
  end

  assign kif.key_ready = key_ready;
  assign kif.out_valid = out_valid;
  assign kif.a         = a;
  assign kif.b         = b;
  assign kif.operand   = operand;
  assign kif.disp      = disp;
  assign kif.digit_ovf = ovf;

endmodule

// File: tb/tb_calc_key_entry.sv
// Bench for calc_key_entry: directed key sequences plus random key streams,
// checked every cycle against a keypad model and a result scoreboard.
module tb_calc_key_entry;

  localparam int NB   = 48;
  localparam int MAXD = 14;

  typedef struct {
    longint a;
    longint b;
    int     op;
  } res_t;

  logic clk;
  logic rst;
  logic man_ready, rnd_ready, rnd_en, mon_en, done;

  calc_key_if #(.NB(NB)) kif ();

  calc_key_entry #(.NB(NB), .MAX_DIGITS(MAXD)) dut (
    .clk (clk),
    .rst (rst),
    .kif (kif.slave)
  );

  assign kif.out_ready = rnd_en ? rnd_ready : man_ready;

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) begin
    #1;
    rnd_ready = 1'($urandom_range(0, 1));
  end

  // Keypad model: what the calculator front end should show after each accepted key.
  int     phase;  // 0 typing a, 1 typing b, 2 result waiting
  longint mag;
  bit     neg;
  int     nd;
  bit     ovf;
  longint ma, mb;
  int     mop;
  res_t   q[$];
  int     pass_cnt, chk_cnt;

  task automatic check(input string nm, input logic [63:0] act, input logic [63:0] exp);
    chk_cnt++;
    if (act === exp) pass_cnt++;
    else $display("FAIL %s: got %0d required %0d at %0t", nm, $signed(act), $signed(exp), $time);
  endtask

  task automatic model_reset();
    phase = 0; mag = 0; neg = 0; nd = 0; ovf = 0;
    ma = 0; mb = 0; mop = 0;
    q.delete();
  endtask

  task automatic model_key(input int c);
    longint cur;
    res_t   r;
    cur = neg ? -mag : mag;
    if (c <= 9) begin
      if (nd < MAXD) begin
        if (!(mag == 0 && c == 0)) nd++;
        mag = mag * 10 + c;
      end else begin
        ovf = 1;
      end
    end else if (c == 16) begin
      neg = !neg;
    end else if (c >= 10 && c <= 13) begin
      if (phase == 0) begin
        ma = cur; mop = c - 10;
        mag = 0; neg = 0; nd = 0;
        phase = 1;
      end else if (nd == 0 && mag == 0 && !neg) begin
        mop = c - 10;
      end
    end else if (c == 14) begin
      if (phase == 1) begin
        mb = cur;
        r.a = ma; r.b = cur; r.op = mop;
        q.push_back(r);
        phase = 2;
      end
    end else if (c == 15) begin
      phase = 0; mag = 0; neg = 0; nd = 0; ovf = 0;
    end
  endtask

  // Monitor: compare outputs against the model, then advance the model for the coming edge.
  always @(negedge clk) begin
    res_t r;
    if (mon_en) begin
      check("disp", 64'(kif.disp), neg ? -mag : mag);
      check("digit_ovf", 64'(kif.digit_ovf), 64'(ovf));
      check("key_ready", 64'(kif.key_ready), 64'(phase != 2));
      check("out_valid", 64'(kif.out_valid), 64'(phase == 2));
      check("a", 64'(kif.a), ma);
      check("b", 64'(kif.b), mb);
      check("operand", 64'(kif.operand), 64'(mop));
      if (rst) begin
        model_reset();
      end else if (phase == 2) begin
        if (kif.out_ready) begin
          if (q.size() == 0) begin
            check("sb_nonempty", 64'(0), 64'(1));
          end else begin
            r = q.pop_front();
            check("sb_a", 64'(kif.a), r.a);
            check("sb_b", 64'(kif.b), r.b);
            check("sb_operand", 64'(kif.operand), 64'(r.op));
          end
          phase = 0; mag = 0; neg = 0; nd = 0; ovf = 0;
        end
      end else if (kif.key_valid) begin
        model_key(int'(kif.key_code));
      end
      if (done) begin
        check("sb_drained", 64'(q.size()), 64'(0));
        $display("%0d/%0d checks passed", pass_cnt, chk_cnt);
        $finish;
      end
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic send_key(input int c);
    int n;
    n = 0;
    while (kif.key_ready !== 1'b1) begin
      tick(1);
      n++;
      if (n > 400) begin
        $display("FAIL key_ready_timeout: key_ready=%b required 1", kif.key_ready);
        $fatal(1, "key entry stalled");
      end
    end
    kif.key_valid = 1'b1;
    kif.key_code  = 5'(c);
    tick(1);
    kif.key_valid = 1'b0;
    kif.key_code  = 5'($urandom);
  endtask

  task automatic send_seq(input int keys[$]);
    foreach (keys[i]) send_key(keys[i]);
  endtask

  task automatic pulse_reset();
    rst = 1'b1;
    tick(1);
    rst = 1'b0;
  endtask

  initial begin
    int r;
    rst = 1'b1; man_ready = 1'b0; rnd_en = 1'b0; mon_en = 1'b0; done = 1'b0;
    kif.key_valid = 1'b0; kif.key_code = 5'd0;
    tick(1);
    mon_en = 1'b1;
    tick(1);
    rst = 1'b0;
    tick(1);

    // 20 / 3, held off by the consumer for five cycles
    send_seq('{2, 0, 13, 3, 14});
    tick(5);
    man_ready = 1'b1;
    tick(2);

    send_seq('{1, 13, 14});
    send_seq('{0, 13, 3, 14});
    send_seq('{7, 16, 10, 12, 5, 16, 14});

    // Digit overflow and clear
    for (int i = 0; i < 15; i++) send_key(9);
    tick(1);
    send_key(15);
    tick(1);

    // Reset mid-entry, then a fresh subtraction
    send_seq('{4, 10, 6});
    pulse_reset();
    send_seq('{1, 11, 1, 14});
    tick(2);

    // '=' and unknown codes in ENTER_A are ignored
    send_seq('{5, 14, 20, 31, 10, 14});
    tick(2);

    // Reset while a result is waiting
    man_ready = 1'b0;
    send_seq('{3, 12, 2, 14});
    tick(2);
    pulse_reset();
    man_ready = 1'b1;
    tick(1);

    rnd_en = 1'b1;
    for (int i = 0; i < 600; i++) begin
      r = $urandom_range(0, 99);
      if (r < 55)      send_key($urandom_range(0, 9));
      else if (r < 62) send_key(16);
      else if (r < 75) send_key($urandom_range(10, 13));
      else if (r < 85) send_key(14);
      else if (r < 88) send_key(15);
      else if (r < 93) send_key($urandom_range(17, 31));
      else             tick($urandom_range(1, 3));
    end
    rnd_en = 1'b0;
    man_ready = 1'b1;
    tick(4);
    done = 1'b1;
    tick(4);
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "time limit");
  end

endmodule
